// File: rtl/mpa_debug_loader.sv
// rtl/mpa_debug_loader.sv - debug back-door loader: streams burst writes/reads into a frozen target
// Commands are accepted only in IDLE; dbg_mem_debug stays up across commands until RUN.
module mpa_debug_loader #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int SETTLE_CYCLES = 2,
  parameter int READ_LATENCY  = 1
) (
  input  logic                     CLK,
  input  logic                     HW_RSTn,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [1:0]               cmd_func,
  input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
  input  logic [7:0]               cmd_len,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     err,
  output logic                     busy,
  output logic                     halted,
  output logic                     dbg_mem_debug,
  output logic [1:0]               dbg_func,
  output logic [ADDRESS_WIDTH-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0]    dbg_din,
  output logic                     dbg_we,
  output logic                     dbg_re,
  input  logic [DATA_WIDTH-1:0]    dbg_dout
);

  localparam logic [1:0] OP_WRITE = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_HALT  = 2'd2;
  localparam logic [1:0] OP_RUN   = 2'd3;
  localparam int         CW       = 16;

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_WDATA, S_WSTROBE, S_RSTROBE, S_RWAIT, S_RSP
  } state_t;

  state_t                   state_q, state_d;
  logic                     mem_debug_q;
  logic [1:0]               func_q, op_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [7:0]               len_q;
  logic [CW-1:0]            cnt_q;
  logic [DATA_WIDTH-1:0]    din_q, rd_data_q;
  logic                     err_q;
  logic                     cmd_bad;
  state_t                   post_settle;

  assign cmd_bad = !(cmd_func == 2'd1 || cmd_func == 2'd2) ||
                   (!cmd_op[1] && cmd_len == 8'd0);

  always_comb begin
    post_settle = S_IDLE;
    if (op_q == OP_WRITE)     post_settle = S_WDATA;
    else if (op_q == OP_READ) post_settle = S_RSTROBE;
  end

  always_ff @(posedge CLK or negedge HW_RSTn) begin
    if (!HW_RSTn) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    wr_ready  = 1'b0;
    rd_valid  = 1'b0;
    dbg_we    = 1'b0;
    dbg_re    = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid && !cmd_bad && cmd_op != OP_RUN) begin
          if (!mem_debug_q && SETTLE_CYCLES > 0) state_d = S_SETTLE;
          else if (cmd_op == OP_WRITE)           state_d = S_WDATA;
          else if (cmd_op == OP_READ)            state_d = S_RSTROBE;
        end
      end
      S_SETTLE:  if (cnt_q == CW'(1)) state_d = post_settle;
      S_WDATA: begin
        wr_ready = 1'b1;
        if (wr_valid) state_d = S_WSTROBE;
      end
      S_WSTROBE: begin
        dbg_we  = mem_debug_q;
        state_d = (len_q == 8'd1) ? S_IDLE : S_WDATA;
      end
      S_RSTROBE: begin
        dbg_re  = mem_debug_q;
        state_d = (READ_LATENCY > 1) ? S_RWAIT : S_RSP;
      end
      S_RWAIT:   if (cnt_q == CW'(1)) state_d = S_RSP;
      S_RSP: begin
        rd_valid = 1'b1;
        if (rd_ready) state_d = (len_q == 8'd1) ? S_IDLE : S_RSTROBE;
      end
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge HW_RSTn) begin
    if (!HW_RSTn) begin
      mem_debug_q <= 1'b0;
      func_q      <= 2'd0;
      op_q        <= 2'd0;
      addr_q      <= '0;
      len_q       <= 8'd0;
      cnt_q       <= '0;
      din_q       <= '0;
      rd_data_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: if (cmd_valid) begin
          if (cmd_bad) begin
            err_q <= 1'b1;
          end else if (cmd_op == OP_RUN) begin
            mem_debug_q <= 1'b0;
            func_q      <= 2'd0;
          end else begin
            op_q        <= cmd_op;
            mem_debug_q <= 1'b1;
            cnt_q       <= CW'(SETTLE_CYCLES);
            if (cmd_op != OP_HALT) begin
              func_q <= cmd_func;
              addr_q <= cmd_addr;
              len_q  <= cmd_len;
            end
          end
        end
        S_SETTLE:  cnt_q <= cnt_q - CW'(1);
        S_WDATA:   if (wr_valid) din_q <= wr_data;
        S_WSTROBE: begin
          addr_q <= addr_q + ADDRESS_WIDTH'(1);
          len_q  <= len_q - 8'd1;
        end
        S_RSTROBE: begin
          cnt_q <= CW'(READ_LATENCY - 1);
          if (READ_LATENCY <= 1) rd_data_q <= dbg_dout;
        end
        S_RWAIT: begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) rd_data_q <= dbg_dout;
        end
        S_RSP: if (rd_ready) begin
          addr_q <= addr_q + ADDRESS_WIDTH'(1);
          len_q  <= len_q - 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign busy          = (state_q != S_IDLE);
  assign halted        = mem_debug_q;
  assign dbg_mem_debug = mem_debug_q;
  assign dbg_func      = func_q;
  assign dbg_addr      = addr_q;
  assign dbg_din       = din_q;
  assign rd_data       = rd_data_q;
  assign err           = err_q;

endmodule

// File: tb/tb_mpa_debug_loader.sv
// tb/tb_mpa_debug_loader.sv - scoreboard bench for mpa_debug_loader
module tb_mpa_debug_loader;

  logic        CLK = 1'b0;
  logic        HW_RSTn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [1:0]  cmd_func = 2'd0;
  logic [31:0] cmd_addr = 32'd0;
  logic [7:0]  cmd_len = 8'd0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [31:0] wr_data = 32'd0;
  logic        rd_valid;
  logic        rd_ready = 1'b0;
  logic [31:0] rd_data;
  logic        err, busy, halted, dbg_mem_debug, dbg_we, dbg_re;
  logic [1:0]  dbg_func;
  logic [31:0] dbg_addr, dbg_din, dbg_dout;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  func;
  } wr_exp_t;

  wr_exp_t     wr_q[$];
  logic [31:0] rd_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int we_cnt = 0;
  int re_cnt = 0;
  int err_cnt = 0;
  logic prev_we = 1'b0;
  logic prev_re = 1'b0;

  always #5 CLK = ~CLK;

  assign dbg_dout = dbg_addr + 32'h100;

  mpa_debug_loader #(
    .DATA_WIDTH(32), .ADDRESS_WIDTH(32), .SETTLE_CYCLES(2), .READ_LATENCY(1)
  ) dut (
    .CLK(CLK), .HW_RSTn(HW_RSTn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_func(cmd_func),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .err(err), .busy(busy), .halted(halted),
    .dbg_mem_debug(dbg_mem_debug), .dbg_func(dbg_func), .dbg_addr(dbg_addr),
    .dbg_din(dbg_din), .dbg_we(dbg_we), .dbg_re(dbg_re), .dbg_dout(dbg_dout)
  );

  // Scoreboard side: pops expectations as the DUT strobes/hands off data.
  always @(negedge CLK) begin
    if (HW_RSTn) begin
      if (dbg_we || dbg_re) begin
        n_cmp++;
        if ((dbg_we && dbg_re) || !dbg_mem_debug || (dbg_we && prev_we) || (dbg_re && prev_re)) begin
          n_bad++;
          $display("FAIL strobe_rules: we=%0b re=%0b mem_debug=%0b prev_we=%0b prev_re=%0b",
                   dbg_we, dbg_re, dbg_mem_debug, prev_we, prev_re);
        end
      end
      if (dbg_we) begin
        we_cnt++;
        n_cmp++;
        if (wr_q.size() == 0) begin
          n_bad++;
          $display("FAIL we_unexpected: addr=%h din=%h, no write expected", dbg_addr, dbg_din);
        end else begin
          wr_exp_t e;
          e = wr_q.pop_front();
          if ({dbg_addr, dbg_din, dbg_func} !== {e.addr, e.data, e.func}) begin
            n_bad++;
            $display("FAIL we_beat: got addr=%h din=%h func=%0d, want addr=%h din=%h func=%0d",
                     dbg_addr, dbg_din, dbg_func, e.addr, e.data, e.func);
          end
        end
      end
      if (dbg_re) re_cnt++;
      if (err) err_cnt++;
      if (rd_valid && rd_ready) begin
        n_cmp++;
        if (rd_q.size() == 0) begin
          n_bad++;
          $display("FAIL rd_unexpected: rd_data=%h, no read expected", rd_data);
        end else begin
          logic [31:0] r;
          r = rd_q.pop_front();
          if (rd_data !== r) begin
            n_bad++;
            $display("FAIL rd_beat: got %h want %h", rd_data, r);
          end
        end
      end
      prev_we = dbg_we;
      prev_re = dbg_re;
    end else begin
      prev_we = 1'b0;
      prev_re = 1'b0;
    end
  end

  task automatic send_cmd(input logic [1:0] op, input logic [1:0] func,
                          input logic [31:0] addr, input logic [7:0] len);
    int t = 0;
    cmd_op = op; cmd_func = func; cmd_addr = addr; cmd_len = len; cmd_valid = 1'b1;
    while (!cmd_ready && t < 200) begin t++; @(negedge CLK); end
    if (!cmd_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL cmd_timeout: cmd_ready=%0b want 1", cmd_ready);
    end
    @(posedge CLK); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wr_beat(input logic [31:0] d);
    int t = 0;
    wr_data = d; wr_valid = 1'b1;
    while (!wr_ready && t < 50) begin t++; @(negedge CLK); end
    if (!wr_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL wr_timeout: wr_ready=%0b want 1", wr_ready);
    end
    @(posedge CLK); #1;
    wr_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge CLK);
    while (busy && t < 200) begin t++; @(negedge CLK); end
    if (busy) begin
      n_cmp++; n_bad++;
      $display("FAIL idle_timeout: busy=%0b want 0", busy);
    end
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if ({cmd_ready, busy, halted, dbg_mem_debug, dbg_we, dbg_re, wr_ready, rd_valid, err} !== 9'b1_0000_0000) begin
      n_bad++;
      $display("FAIL reset_outputs: ready/busy/halted/md/we/re/wrr/rdv/err=%b want 100000000",
               {cmd_ready, busy, halted, dbg_mem_debug, dbg_we, dbg_re, wr_ready, rd_valid, err});
    end
    n_cmp++;
    if ({dbg_func, dbg_addr, dbg_din, rd_data} !== 98'd0) begin
      n_bad++;
      $display("FAIL reset_buses: func=%0d addr=%h din=%h rd=%h want 0", dbg_func, dbg_addr, dbg_din, rd_data);
    end
    @(negedge CLK);
    HW_RSTn = 1'b1;
  endtask

  task automatic test_write();
    int n = 0;
    int we0 = we_cnt;
    wr_q.push_back('{32'h10, 32'hA, 2'd1});
    wr_q.push_back('{32'h11, 32'hB, 2'd1});
    wr_q.push_back('{32'h12, 32'hC, 2'd1});
    send_cmd(2'd0, 2'd1, 32'h10, 8'd3);
    @(negedge CLK);
    n_cmp++;
    if (dbg_mem_debug !== 1'b1 || halted !== 1'b1) begin
      n_bad++;
      $display("FAIL write_md_rise: mem_debug=%0b halted=%0b want 1", dbg_mem_debug, halted);
    end
    while (!wr_ready && n < 20) begin n++; @(negedge CLK); end
    n_cmp++;
    if (n != 2) begin
      n_bad++;
      $display("FAIL settle_cycles: got %0d want 2", n);
    end
    wr_beat(32'hA);
    wr_beat(32'hB);
    wr_beat(32'hC);
    wait_idle();
    n_cmp++;
    if (we_cnt - we0 != 3) begin
      n_bad++;
      $display("FAIL write_we_count: got %0d want 3", we_cnt - we0);
    end
  endtask

  task automatic test_read_stall();
    int t = 0;
    int re0 = re_cnt;
    rd_q.push_back(32'h104);
    rd_q.push_back(32'h105);
    send_cmd(2'd1, 2'd2, 32'h4, 8'd2);
    n_cmp++;
    if (busy !== 1'b1 || dbg_re !== 1'b1 || dbg_func !== 2'd2) begin
      n_bad++;
      $display("FAIL read_no_settle: busy=%0b re=%0b func=%0d want 1 1 2", busy, dbg_re, dbg_func);
    end
    while (!rd_valid && t < 20) begin t++; @(negedge CLK); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (rd_valid !== 1'b1 || rd_data !== 32'h104) begin
        n_bad++;
        $display("FAIL read_stall_%0d: rd_valid=%0b rd_data=%h want 1 00000104", i, rd_valid, rd_data);
      end
      @(negedge CLK);
    end
    @(posedge CLK); #1;
    rd_ready = 1'b1;
    wait_idle();
    rd_ready = 1'b0;
    n_cmp++;
    if (re_cnt - re0 != 2) begin
      n_bad++;
      $display("FAIL read_re_count: got %0d want 2", re_cnt - re0);
    end
  endtask

  task automatic test_addr_wrap();
    wr_q.push_back('{32'hFFFF_FFFF, 32'h1111, 2'd1});
    wr_q.push_back('{32'h0000_0000, 32'h2222, 2'd1});
    send_cmd(2'd0, 2'd1, 32'hFFFF_FFFF, 8'd2);
    wr_beat(32'h1111);
    wr_beat(32'h2222);
    wait_idle();
  endtask

  task automatic test_reject();
    int we0, re0, e0;
    send_cmd(2'd3, 2'd1, 32'h0, 8'd1);
    @(negedge CLK);
    n_cmp++;
    if (halted !== 1'b0 || dbg_func !== 2'd0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL run_clears: halted=%0b func=%0d busy=%0b want 0 0 0", halted, dbg_func, busy);
    end
    we0 = we_cnt; re0 = re_cnt; e0 = err_cnt;
    send_cmd(2'd0, 2'd3, 32'h40, 8'd1);
    @(negedge CLK);
    n_cmp++;
    if (err !== 1'b1 || busy !== 1'b0 || dbg_mem_debug !== 1'b0) begin
      n_bad++;
      $display("FAIL reject_func: err=%0b busy=%0b md=%0b want 1 0 0", err, busy, dbg_mem_debug);
    end
    @(negedge CLK);
    send_cmd(2'd1, 2'd1, 32'h40, 8'd0);
    @(negedge CLK);
    n_cmp++;
    if (err !== 1'b1 || busy !== 1'b0 || dbg_mem_debug !== 1'b0) begin
      n_bad++;
      $display("FAIL reject_len0: err=%0b busy=%0b md=%0b want 1 0 0", err, busy, dbg_mem_debug);
    end
    repeat (3) @(negedge CLK);
    n_cmp++;
    if (err_cnt - e0 != 2 || we_cnt != we0 || re_cnt != re0 || dbg_mem_debug !== 1'b0) begin
      n_bad++;
      $display("FAIL reject_effects: errs=%0d we=%0d re=%0d md=%0b want 2 0 0 0",
               err_cnt - e0, we_cnt - we0, re_cnt - re0, dbg_mem_debug);
    end
  endtask

  task automatic test_reset_mid_burst();
    int seen = 0;
    int t = 0;
    int e0 = err_cnt;
    rd_q.push_back(32'h120);
    rd_ready = 1'b1;
    send_cmd(2'd1, 2'd1, 32'h20, 8'd4);
    while (seen < 2 && t < 100) begin
      @(negedge CLK);
      t++;
      if (dbg_re) seen++;
    end
    HW_RSTn = 1'b0;
    #1;
    n_cmp++;
    if ({dbg_we, dbg_re, dbg_mem_debug, halted, rd_valid, busy, err} !== 7'd0 ||
        {dbg_func, dbg_addr, dbg_din} !== 66'd0 || cmd_ready !== 1'b1 || seen != 2) begin
      n_bad++;
      $display("FAIL reset_mid: we=%0b re=%0b md=%0b rdv=%0b busy=%0b func=%0d addr=%h ready=%0b seen=%0d want zeros ready=1 seen=2",
               dbg_we, dbg_re, dbg_mem_debug, rd_valid, busy, dbg_func, dbg_addr, cmd_ready, seen);
    end
    rd_ready = 1'b0;
    repeat (2) @(negedge CLK);
    HW_RSTn = 1'b1;
    send_cmd(2'd2, 2'd1, 32'h0, 8'd1);
    n_cmp++;
    if (halted !== 1'b1 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL halt_after_reset: halted=%0b busy=%0b want 1 1", halted, busy);
    end
    wait_idle();
    send_cmd(2'd3, 2'd1, 32'h0, 8'd1);
    n_cmp++;
    if (halted !== 1'b0 || dbg_func !== 2'd0) begin
      n_bad++;
      $display("FAIL run_after_halt: halted=%0b func=%0d want 0 0", halted, dbg_func);
    end
    @(negedge CLK);
    n_cmp++;
    if (err_cnt != e0) begin
      n_bad++;
      $display("FAIL reset_no_err: err pulses=%0d want 0", err_cnt - e0);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_stall();
    test_addr_wrap();
    test_reject();
    test_reset_mid_burst();
    n_cmp++;
    if (wr_q.size() != 0 || rd_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: wr left=%0d rd left=%0d want 0 0", wr_q.size(), rd_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mpa_debug_loader.md
MPA_DEBUG_LOADER -- requirements
Module: mpa_debug_loader

Interface
REQ-001 Parameters SHALL be:
- DATA_WIDTH, default 32: back-door data width.
- ADDRESS_WIDTH, default 32: back-door address width.
- SETTLE_CYCLES, default 2: idle cycles after raising dbg_mem_debug, before the first access.
- READ_LATENCY, default 1: cycles from the dbg_re pulse to dbg_dout sampling; minimum 1.
REQ-002 Ports SHALL be:
- CLK  in  1  sole clock, rising edge.
- HW_RSTn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_op  in  2  0=WRITE, 1=READ, 2=HALT, 3=RUN.
- cmd_func  in  2  target: 1=IM, 2=DM.
- cmd_addr  in  ADDRESS_WIDTH  start word address.
- cmd_len  in  8  beat count, 1..255.
- wr_valid / wr_ready  in/out  1  write-data handshake.
- wr_data  in  DATA_WIDTH  write beat data.
- rd_valid / rd_ready  out/in  1  read-data handshake.
- rd_data  out  DATA_WIDTH  read beat data.
- err  out  1  one-cycle pulse on a rejected command.
- busy  out  1  FSM not IDLE.
- halted  out  1  mirrors dbg_mem_debug.
- dbg_mem_debug  out  1  target freeze / back-door enable.
- dbg_func  out  2  target select.
- dbg_addr  out  ADDRESS_WIDTH  back-door address.
- dbg_din  out  DATA_WIDTH  back-door write data.
- dbg_we / dbg_re  out  1  one-cycle access strobes.
- dbg_dout  in  DATA_WIDTH  back-door read data.

Function
REQ-003 FSM states SHALL be IDLE, SETTLE, WDATA, WSTROBE, RSTROBE, RWAIT, RSP; cmd_ready SHALL be high only in IDLE.
REQ-004 WRITE or READ accepted with cmd_func in {1,2} and cmd_len != 0 SHALL latch func, addr and len; if dbg_mem_debug=0 it SHALL be raised on the next cycle and the FSM SHALL spend exactly SETTLE_CYCLES cycles in SETTLE; if already 1, SETTLE SHALL be skipped.
REQ-005 A command with cmd_func in {0,3}, or a WRITE/READ with cmd_len=0, SHALL be accepted, pulse err for one cycle, and cause no dbg strobe and no state change beyond IDLE.
REQ-006 WRITE beat: in WDATA wr_ready=1; on the wr_valid handshake wr_data SHALL be latched into dbg_din, and on the following cycle (WSTROBE) dbg_we=1 for exactly one cycle with dbg_addr, dbg_din and dbg_func stable.
REQ-007 READ beat: dbg_re=1 for exactly one cycle (RSTROBE); the FSM SHALL wait READ_LATENCY-1 cycles in RWAIT, then capture dbg_dout into rd_data on the cycle entering RSP; rd_valid SHALL stay high and rd_data stable until rd_ready.
REQ-008 After each beat, dbg_addr SHALL increment by 1, wrapping modulo 2^ADDRESS_WIDTH, and the remaining count SHALL decrement; at zero the FSM SHALL return to IDLE, otherwise it SHALL start the next beat with no SETTLE.
REQ-009 dbg_we and dbg_re SHALL never be high simultaneously and SHALL be low whenever dbg_mem_debug=0.
REQ-010 dbg_mem_debug SHALL be sticky after WRITE/READ/HALT and SHALL clear only on RUN or reset.
REQ-011 HALT SHALL raise dbg_mem_debug and pass through SETTLE when it was low, else complete in one cycle.
REQ-012 RUN SHALL clear dbg_mem_debug and set dbg_func=0 on the next cycle, then return to IDLE.
REQ-013 dbg_func SHALL hold its latched value while dbg_mem_debug=1 and SHALL be 0 otherwise.

Reset
REQ-014 HW_RSTn low SHALL immediately force IDLE and set all outputs to 0 except cmd_ready=1, including mid-burst; any partial burst SHALL be discarded without an err pulse.
REQ-015 After reset, the first rising CLK edge with HW_RSTn high SHALL be able to accept a command.

Verification
REQ-016 WRITE func=1 addr=0x10 len=3, data 0xA,0xB,0xC, SETTLE_CYCLES=2 -> dbg_mem_debug rises, 2 settle cycles, then three single-cycle dbg_we pulses at addr 0x10, 0x11, 0x12 with din 0xA, 0xB, 0xC.
REQ-017 READ func=2 addr=0x4 len=2 with target returning addr+0x100, READ_LATENCY=1, rd_ready held low 3 cycles -> rd_data=0x104 held stable for the stall, then 0x105; exactly two dbg_re pulses.
REQ-018 WRITE addr=0xFFFFFFFF len=2 -> second dbg_we at addr 0x00000000.
REQ-019 cmd_func=3 and, separately, cmd_len=0 -> one err pulse each; dbg_we, dbg_re and dbg_mem_debug stay 0.
REQ-020 HW_RSTn pulled low during the second beat of a len=4 READ -> all dbg outputs 0 in the same cycle, cmd_ready=1; the next HALT then RUN cycle toggles halted 1 then 0.
